// File: rtl/pipe_pkg.sv
// Shared encodings and bundle widths for the pipeline stage buffers.
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 64;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry (control + data) with load enable and async clear.
module pipe_entry_reg #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
//   state   | meaning
//   EMPTY   | no entry held, out_valid=0
//   ONE     | main holds the output entry
//   TWO     | main holds output, skid holds the next entry, in_ready=0
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    localparam int W = CTRL_W + DATA_W;

    state_t       state;
    state_t       state_nxt;
    logic         valid_q;
    logic         ready_q;
    logic [1:0]   occ_q;
    logic         accept;
    logic         consume;
    logic         main_load;
    logic         skid_load;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    // Without a skid entry the ONE state can only accept while also draining,
    // so the same state machine never reaches TWO.
    assign in_ready = (SKID != 0) ? ready_q : (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = {in_ctrl, in_data};
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    main_load = accept;
                    if (accept) state_nxt = S_ONE;
                end
                S_ONE: begin
                    main_load = accept && consume;
                    skid_load = accept && !consume;
                    if (accept && !consume) state_nxt = S_TWO;
                    else if (!accept && consume) state_nxt = S_EMPTY;
                end
                S_TWO: begin
                    main_load = consume;
                    main_d    = skid_q;
                    if (consume) state_nxt = S_ONE;
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= ST_EMPTY;
        end else begin
            state   <= state_nxt;
            valid_q <= (state_nxt != S_EMPTY);
            ready_q <= (state_nxt != S_TWO);
            occ_q   <= state_nxt;
        end
    end

    pipe_entry_reg #(.W(W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(.W(W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .d     ({in_ctrl, in_data}),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign out_valid = valid_q;
    assign out_ctrl  = valid_q ? main_q[W-1 -: CTRL_W] : '0;
    assign out_data  = main_q[DATA_W-1:0];
    assign occupancy = occ_q;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench driving a SKID=1 (index 0) and a SKID=0 (index 1) instance in parallel.
module tb_pipe_stage_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b1;

    wire [1:0]       ir;
    wire [1:0]       ov;
    wire [1:0][1:0]  oc;
    wire [1:0][63:0] od;
    wire [1:0][1:0]  occ;

    int total = 0;
    int bad = 0;
    int pending [2];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(2), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
        .occupancy(occ[0])
    );

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(2), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_mon
        logic [65:0] sb [$];
        logic [65:0] exp_e;
        always @(negedge clk) begin
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (ov[k] && out_ready) begin
                    chk("sb_has_entry", k, 128'(sb.size() != 0), 128'(1));
                    if (sb.size() != 0) begin
                        exp_e = sb.pop_front();
                        chk("out_entry", k, 128'({oc[k], od[k]}), 128'(exp_e));
                    end
                end
                if (!ov[k]) chk("ctrl_zero_idle", k, 128'(oc[k]), 128'(0));
                if (flush) sb.delete();
                else if (in_valid && ir[k]) sb.push_back({in_ctrl, in_data});
            end
            pending[k] = sb.size();
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        for (int k = 0; k < 2; k++) chk("drained", k, 128'(pending[k]), 128'(0));
    endtask

    initial begin
        // reset then single entry
        rst_n = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 128'(ov[k]), 128'(0));
            chk("rst_ctrl", k, 128'(oc[k]), 128'(0));
            chk("rst_data", k, 128'(od[k]), 128'(0));
            chk("rst_occ", k, 128'(occ[k]), 128'(0));
            chk("rst_in_ready", k, 128'(ir[k]), 128'(1));
        end
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        in_ctrl  = 2'b10;
        in_data  = 64'h0000_0001_DEAD_BEEF;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("single_valid", k, 128'(ov[k]), 128'(1));
            chk("single_ctrl", k, 128'(oc[k]), 128'(2'b10));
            chk("single_data", k, 128'(od[k]), 128'(64'h0000_0001_DEAD_BEEF));
            chk("single_occ1", k, 128'(occ[k]), 128'(1));
        end
        step();
        for (int k = 0; k < 2; k++) chk("single_occ0", k, 128'(occ[k]), 128'(0));

        // stall fill
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b01;
        in_data   = 64'h11;
        step();
        in_data = 64'h22;
        step();
        in_valid = 1'b0;
        chk("fill_occ", 0, 128'(occ[0]), 128'(2));
        chk("fill_in_ready", 0, 128'(ir[0]), 128'(0));
        chk("fill_data", 0, 128'(od[0]), 128'(64'h11));
        chk("fill_occ", 1, 128'(occ[1]), 128'(1));
        chk("fill_in_ready", 1, 128'(ir[1]), 128'(0));
        chk("fill_data", 1, 128'(od[1]), 128'(64'h11));
        out_ready = 1'b1;
        step();
        chk("release_second", 0, 128'({ov[0], od[0]}), 128'({1'b1, 64'h22}));
        chk("release_occ", 0, 128'(occ[0]), 128'(1));
        step();
        chk("release_empty", 0, 128'(occ[0]), 128'(0));

        // full-throughput stream
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 2'(i);
            in_data  = 64'(i);
            for (int k = 0; k < 2; k++) chk("stream_in_ready", k, 128'(ir[k]), 128'(1));
            step();
            for (int k = 0; k < 2; k++) begin
                chk("stream_out", k, 128'({ov[k], od[k]}), 128'({1'b1, 64'(i)}));
                chk("stream_occ", k, 128'(occ[k] <= 2'd1), 128'(1));
            end
        end
        drain();

        // flush with simultaneous in_valid while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_data   = 64'h44;
        step();
        in_data = 64'h55;
        step();
        chk("flush_pre_occ", 0, 128'(occ[0]), 128'(2));
        flush   = 1'b1;
        in_data = 64'h33;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("flush_valid", k, 128'(ov[k]), 128'(0));
            chk("flush_ctrl", k, 128'(oc[k]), 128'(0));
            chk("flush_occ", k, 128'(occ[k]), 128'(0));
            chk("flush_in_ready", k, 128'(ir[k]), 128'(1));
            chk("flush_data_hold", k, 128'(od[k]), 128'(64'h44));
        end
        drain();

        // random back-pressure
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_ctrl   = 2'($urandom_range(0, 3));
            in_data   = {$urandom(), $urandom()};
            step();
        end
        drain();

        // async reset mid-stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_data   = 64'h66;
        step();
        in_data = 64'h77;
        step();
        in_valid = 1'b0;
        chk("areset_pre_occ", 0, 128'(occ[0]), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("areset_valid", k, 128'(ov[k]), 128'(0));
            chk("areset_ctrl", k, 128'(oc[k]), 128'(0));
            chk("areset_occ", k, 128'(occ[k]), 128'(0));
        end
        step();
        rst_n = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for the 5-stage datapath; successor to the fixed-width, always-enabled MEM->WB latch.
- Carries a control bundle and a data bundle between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshaking, stall back-pressure, flush (bubble insertion) and an optional 2-entry skid buffer that registers the upstream ready path.
- Control bits are forced to zero when the stage holds no valid entry, so the writeback stage never issues a spurious register write.

Parameters:
- DATA_W, 64, width of data bundle (e.g. rdata and ALU_res concatenated = 2x32).
- CTRL_W, 2, width of control bundle (e.g. RegDst, RegWrite).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held entries; synchronous.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  this stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream stage consumes the entry this cycle (deasserted = stall).
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle; holds its last value when out_valid=0.
- occupancy  out  2  number of entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 when SKID=1.
  - Reset mid-transfer drops all entries.
- Transfer rules: accept when in_valid & in_ready at a clk edge; consume when out_valid & out_ready at a clk edge.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Main register loads on accept.
  - out_valid next = accept | (out_valid & !out_ready).
- SKID=1: state machine with main and skid registers; out_* always driven from main.
  - EMPTY:
    - accept -> ONE, main <= in.
  - ONE:
    - accept & consume -> ONE, main <= in.
    - accept & !consume -> TWO, skid <= in.
    - !accept & consume -> EMPTY.
  - TWO:
    - in_ready=0, no accept.
    - consume -> ONE, main <= skid.
  - in_ready is a register output: 1 in EMPTY and ONE, 0 in TWO. It never depends on out_ready combinationally.
- Flush:
  - Next state is EMPTY and out_valid=0, regardless of simultaneous accept or consume; flush wins.
  - The entry consumed in the flush cycle is still transferred (downstream saw valid & ready).
  - in_ready=1 in the following cycle.
- Ordering: entries leave in accept order; no loss or duplication under any pattern of out_ready.
- Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data do not change.
- occupancy: EMPTY=0, ONE=1, TWO=2. Registered, updated with state.
- No arithmetic; data is passed through bit-exact.

Decomposition:
- Shared package pipe_pkg:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - standard bundle widths MEMWB_CTRL_W=2 and MEMWB_DATA_W=64, so stage instances agree.
- One natural sub-module: pipe_entry_reg, a CTRL_W+DATA_W register with load enable and asynchronous clear. It is instantiated as main and skid; the skid instance is omitted when SKID=0.

Test Plan:
- Reset then single entry: rst_n low 3 cycles, then in_valid=1, in_ctrl=2'b10, in_data=64'h0000_0001_DEAD_BEEF, out_ready=1 -> out_valid=1 one cycle later with identical ctrl/data; occupancy 0->1->0.
- Stall fill (SKID=1): out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0 on the cycle after B is accepted, out_data holds 0x11; release out_ready -> outputs 0x11 then 0x22 in consecutive cycles.
- Full-throughput stream: 16 back-to-back entries 0..15 with out_ready=1 -> 16 consecutive valid outputs in order, in_ready never drops, occupancy never exceeds 1.
- Flush with simultaneous accept: occupancy=2, assert flush with in_valid=1 (data 0x33) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x33 never appears at the output.
- Random back-pressure: random in_valid and out_ready at 50% for 1000 cycles on SKID=0 and SKID=1 builds -> scoreboard shows in-order, lossless, duplicate-free delivery; out_ctrl=0 whenever out_valid=0.
- Asynchronous reset mid-stall: occupancy=2, drop rst_n between clock edges -> out_valid, out_ctrl and occupancy clear immediately without waiting for a clock edge.
